// File: rtl/tap_ir_dr_regs_if.sv
// tap_ir_dr_regs_if: TAP strobes, serial data and exported registers between the TAP controller side and the IR/DR block
interface tap_ir_dr_regs_if #(
    parameter int IR_W   = 4,
    parameter int USER_W = 16
);
    logic              trst_st;
    logic              c_IR;
    logic              sh_IR;
    logic              u_IR;
    logic              c_DR;
    logic              sh_DR;
    logic              u_DR;
    logic              tdi;
    logic              tdo;
    logic              tdo_en;
    logic [IR_W-1:0]   ir_out;
    logic [USER_W-1:0] user_reg;
    logic              user_upd;

    modport master (
        output trst_st, c_IR, sh_IR, u_IR, c_DR, sh_DR, u_DR, tdi,
        input  tdo, tdo_en, ir_out, user_reg, user_upd
    );

    modport slave (
        input  trst_st, c_IR, sh_IR, u_IR, c_DR, sh_DR, u_DR, tdi,
        output tdo, tdo_en, ir_out, user_reg, user_upd
    );
endinterface

// File: rtl/tap_ir_dr_regs.sv
// tap_ir_dr_regs: JTAG instruction register, BYPASS/IDCODE/USER data registers and registered TDO path
module tap_ir_dr_regs #(
    parameter int                IR_W      = 4,
    parameter int                USER_W    = 16,
    parameter logic [31:0]       IDCODE    = 32'h1000_0001,
    parameter logic [IR_W-1:0]   IDCODE_OP = IR_W'(4'b0001),
    parameter logic [IR_W-1:0]   USER_OP   = IR_W'(4'b0010),
    parameter logic [USER_W-1:0] USER_RST  = '0
) (
    input logic               clk,
    input logic               reset,
    tap_ir_dr_regs_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_NONE,
        OP_CAP_IR,
        OP_SH_IR,
        OP_UPD_IR,
        OP_CAP_DR,
        OP_SH_DR,
        OP_UPD_DR
    } op_e;

    localparam logic [IR_W-1:0] IR_CAP = IR_W'(2'b01);

    op_e               op;
    logic [IR_W-1:0]   ir_sh;
    logic [IR_W-1:0]   ir_out;
    logic              byp;
    logic [31:0]       dr_sh;
    logic [USER_W-1:0] user_reg;
    logic [USER_W-1:0] user_nx;
    logic              tdo;
    logic              tdo_en;
    logic              user_upd;
    logic              sel_id;
    logic              sel_user;

    assign sel_id   = ir_out == IDCODE_OP;
    assign sel_user = !sel_id && ir_out == USER_OP;

    // Resolve overlapping strobes to one winner: IR before DR, capture before shift before update
    always_comb
        op = bus.trst_st ? OP_NONE   :
             bus.c_IR    ? OP_CAP_IR :
             bus.sh_IR   ? OP_SH_IR  :
             bus.u_IR    ? OP_UPD_IR :
             bus.c_DR    ? OP_CAP_DR :
             bus.sh_DR   ? OP_SH_DR  :
             bus.u_DR    ? OP_UPD_DR : OP_NONE;

    // USER chain shifted right by one, tdi entering its top bit
    always_comb begin
        user_nx            = dr_sh[USER_W-1:0] >> 1;
        user_nx[USER_W-1]  = bus.tdi;
    end

    // Register update for the winning operation; reset discards any partial shift
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_sh    <= '0;
            ir_out   <= IDCODE_OP;
            byp      <= 1'b0;
            dr_sh    <= '0;
            user_reg <= USER_RST;
            tdo      <= 1'b0;
            tdo_en   <= 1'b0;
            user_upd <= 1'b0;
        end else begin
            tdo_en   <= op == OP_SH_IR || op == OP_SH_DR;
            user_upd <= op == OP_UPD_DR && sel_user;
            if (bus.trst_st)
                ir_out <= IDCODE_OP;
            if (op == OP_CAP_IR)
                ir_sh <= IR_CAP;
            if (op == OP_SH_IR) begin
                tdo   <= ir_sh[0];
                ir_sh <= {bus.tdi, ir_sh[IR_W-1:1]};
            end
            if (op == OP_UPD_IR)
                ir_out <= ir_sh;
            if (op == OP_CAP_DR) begin
                if (sel_id)
                    dr_sh <= IDCODE;
                else if (sel_user)
                    dr_sh[USER_W-1:0] <= user_reg;
                else
                    byp <= 1'b0;
            end
            if (op == OP_SH_DR) begin
                if (sel_id) begin
                    tdo   <= dr_sh[0];
                    dr_sh <= {bus.tdi, dr_sh[31:1]};
                end else if (sel_user) begin
                    tdo               <= dr_sh[0];
                    dr_sh[USER_W-1:0] <= user_nx;
                end else begin
                    tdo <= byp;
                    byp <= bus.tdi;
                end
            end
            if (op == OP_UPD_DR && sel_user)
                user_reg <= dr_sh[USER_W-1:0];
        end
    end

    assign bus.tdo      = tdo;
    assign bus.tdo_en   = tdo_en;
    assign bus.ir_out   = ir_out;
    assign bus.user_reg = user_reg;
    assign bus.user_upd = user_upd;
endmodule

// File: tb/tb_tap_ir_dr_regs.sv
// tb_tap_ir_dr_regs: vector table, directed corner sequences and randomized strobes against a bit-level reference model
module tb_tap_ir_dr_regs;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tap_ir_dr_regs_if #(.IR_W(4), .USER_W(16)) bus();
    tap_ir_dr_regs #(.IR_W(4), .USER_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic       rst, trst, cir, sir, uir, cdr, sdr, udr, tdi;
        logic       tdo, en;
        logic [3:0] ir;
        logic       upd;
        logic [15:0] user;
    } vec_t;

    localparam longint IDC = 64'h1000_0001;

    int n_cmp = 0;
    int n_err = 0;
    bit rnd_chk = 0;

    int     m_irsh, m_ir, m_byp, m_user, m_tdo, m_en, m_upd;
    longint m_dr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 0; bus.trst_st = 0; bus.c_IR = 0; bus.sh_IR = 0; bus.u_IR = 0;
        bus.c_DR = 0; bus.sh_DR = 0; bus.u_DR = 0; bus.tdi = 0;
    endtask

    // Reference: each register is a chain of n bits; shifting takes the low bit out and puts tdi on top
    task automatic model_step();
        int n;
        longint p, low;
        if (reset) begin
            m_irsh = 0; m_ir = 1; m_byp = 0; m_dr = 0; m_user = 0; m_tdo = 0; m_en = 0; m_upd = 0;
        end else if (bus.trst_st) begin
            m_ir = 1; m_en = 0; m_upd = 0;
        end else begin
            n = (m_ir == 1) ? 32 : (m_ir == 2) ? 16 : 0;
            p = longint'(1) << n;
            m_en = 0;
            m_upd = 0;
            if (bus.c_IR) m_irsh = 1;
            else if (bus.sh_IR) begin
                m_tdo = m_irsh % 2;
                m_irsh = m_irsh / 2 + int'(bus.tdi) * 8;
                m_en = 1;
            end else if (bus.u_IR) m_ir = m_irsh;
            else if (bus.c_DR) begin
                if (n == 32) m_dr = IDC;
                else if (n == 16) m_dr = m_dr - m_dr % 65536 + m_user;
                else m_byp = 0;
            end else if (bus.sh_DR) begin
                m_en = 1;
                if (n == 0) begin
                    m_tdo = m_byp;
                    m_byp = int'(bus.tdi);
                end else begin
                    low = m_dr % p;
                    m_tdo = int'(low % 2);
                    m_dr = m_dr - low + low / 2 + longint'(bus.tdi) * (p / 2);
                end
            end else if (bus.u_DR && n == 16) begin
                m_user = int'(m_dr % 65536);
                m_upd = 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (rnd_chk) begin
            check("rnd.tdo", 32'(bus.tdo), 32'(m_tdo));
            check("rnd.tdo_en", 32'(bus.tdo_en), 32'(m_en));
            check("rnd.ir_out", 32'(bus.ir_out), 32'(m_ir));
            check("rnd.user_reg", 32'(bus.user_reg), 32'(m_user));
            check("rnd.user_upd", 32'(bus.user_upd), 32'(m_upd));
        end
    endtask

    task automatic load_ir(input logic [3:0] v);
        idle(); bus.c_IR = 1; tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.sh_IR = 1; bus.tdi = v[i]; tick();
        end
        idle(); bus.u_IR = 1; tick();
        idle();
    endtask

    task automatic shift_dr(input int n, input logic [31:0] d, output logic [31:0] q);
        q = '0;
        for (int i = 0; i < n; i++) begin
            idle(); bus.sh_DR = 1; bus.tdi = d[i]; tick();
            q[i] = bus.tdo;
        end
        idle();
    endtask

    task automatic cap_dr();
        idle(); bus.c_DR = 1; tick(); idle();
    endtask

    vec_t tv[18];
    logic [31:0] q;
    int en_cnt;

    initial begin
        tv[0]  = '{1,0,0,0,0,0,0,0,0, 0,0,4'h1,0,16'h0};
        tv[1]  = '{0,0,1,0,0,0,0,0,0, 0,0,4'h1,0,16'h0};
        tv[2]  = '{0,0,0,1,0,0,0,0,1, 1,1,4'h1,0,16'h0};
        tv[3]  = '{0,0,0,1,0,0,0,0,1, 0,1,4'h1,0,16'h0};
        tv[4]  = '{0,0,0,1,0,0,0,0,1, 0,1,4'h1,0,16'h0};
        tv[5]  = '{0,0,0,1,0,0,0,0,1, 0,1,4'h1,0,16'h0};
        tv[6]  = '{0,0,0,0,1,0,0,0,0, 0,0,4'hF,0,16'h0};
        tv[7]  = '{0,0,0,0,0,1,0,0,0, 0,0,4'hF,0,16'h0};
        tv[8]  = '{0,0,0,0,0,0,1,0,1, 0,1,4'hF,0,16'h0};
        tv[9]  = '{0,0,0,0,0,0,1,0,0, 1,1,4'hF,0,16'h0};
        tv[10] = '{0,0,0,0,0,0,1,0,1, 0,1,4'hF,0,16'h0};
        tv[11] = '{0,0,0,0,0,0,0,0,0, 0,0,4'hF,0,16'h0};
        tv[12] = '{0,0,1,0,0,1,0,0,0, 0,0,4'hF,0,16'h0};
        tv[13] = '{0,0,0,1,0,0,1,0,0, 1,1,4'hF,0,16'h0};
        tv[14] = '{0,0,0,1,0,0,0,0,0, 0,1,4'hF,0,16'h0};
        tv[15] = '{0,0,0,0,1,0,0,1,0, 0,0,4'h0,0,16'h0};
        tv[16] = '{0,0,0,0,0,0,1,0,0, 1,1,4'h0,0,16'h0};
        tv[17] = '{0,1,1,0,0,0,0,0,0, 1,0,4'h1,0,16'h0};
        idle();
        @(posedge clk); #1;

        // IDCODE readout straight after reset
        reset = 1; tick(); idle();
        check("rst.tdo", 32'(bus.tdo), 32'h0);
        check("rst.tdo_en", 32'(bus.tdo_en), 32'h0);
        check("rst.ir_out", 32'(bus.ir_out), 32'h1);
        check("rst.user_reg", 32'(bus.user_reg), 32'h0);
        check("rst.user_upd", 32'(bus.user_upd), 32'h0);
        cap_dr();
        q = '0; en_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            bus.sh_DR = 1; bus.tdi = 0; tick();
            q[i] = bus.tdo;
            en_cnt += int'(bus.tdo_en);
        end
        idle(); tick();
        check("idcode.data", q, 32'h1000_0001);
        check("idcode.en_cycles", 32'(en_cnt), 32'd32);
        check("idcode.en_after", 32'(bus.tdo_en), 32'h0);

        // IR path, BYPASS and overlap priorities
        for (int i = 0; i < 18; i++) begin
            reset = tv[i].rst; bus.trst_st = tv[i].trst; bus.c_IR = tv[i].cir; bus.sh_IR = tv[i].sir;
            bus.u_IR = tv[i].uir; bus.c_DR = tv[i].cdr; bus.sh_DR = tv[i].sdr; bus.u_DR = tv[i].udr;
            bus.tdi = tv[i].tdi;
            tick();
            check($sformatf("vec%0d.tdo", i), 32'(bus.tdo), 32'(tv[i].tdo));
            if (!(tv[i].sdr && tv[i].cdr)) check($sformatf("vec%0d.tdo_en", i), 32'(bus.tdo_en), 32'(tv[i].en));
            check($sformatf("vec%0d.ir_out", i), 32'(bus.ir_out), 32'(tv[i].ir));
            check($sformatf("vec%0d.user_upd", i), 32'(bus.user_upd), 32'(tv[i].upd));
            check($sformatf("vec%0d.user_reg", i), 32'(bus.user_reg), 32'(tv[i].user));
        end
        idle();

        // USER write and read-back
        load_ir(4'h2);
        check("user.ir_out", 32'(bus.ir_out), 32'h2);
        cap_dr();
        shift_dr(16, 32'hA5C3, q);
        check("user.first_out", q, 32'h0);
        bus.u_DR = 1; tick(); idle();
        check("user.reg", 32'(bus.user_reg), 32'hA5C3);
        check("user.upd_pulse", 32'(bus.user_upd), 32'h1);
        tick();
        check("user.upd_clear", 32'(bus.user_upd), 32'h0);
        cap_dr();
        shift_dr(16, 32'hA5C3, q);
        check("user.readback", q, 32'hA5C3);

        // trst_st restores IDCODE instruction but keeps user_reg
        cap_dr();
        shift_dr(16, 32'h1234, q);
        bus.u_DR = 1; tick(); idle();
        load_ir(4'hF);
        check("trst.ir_before", 32'(bus.ir_out), 32'hF);
        bus.trst_st = 1; tick(); idle();
        check("trst.ir_out", 32'(bus.ir_out), 32'h1);
        check("trst.user_reg", 32'(bus.user_reg), 32'h1234);

        // reset in the middle of a USER shift
        load_ir(4'h2);
        cap_dr();
        shift_dr(8, 32'hFF, q);
        reset = 1; bus.sh_DR = 1; bus.tdi = 1; tick(); idle();
        check("midrst.tdo", 32'(bus.tdo), 32'h0);
        check("midrst.tdo_en", 32'(bus.tdo_en), 32'h0);
        check("midrst.ir_out", 32'(bus.ir_out), 32'h1);
        check("midrst.user_reg", 32'(bus.user_reg), 32'h0);
        check("midrst.user_upd", 32'(bus.user_upd), 32'h0);
        bus.u_DR = 1; tick(); idle();
        check("midrst.no_upd", 32'(bus.user_upd), 32'h0);

        // capture wins over shift under IDCODE
        reset = 1; tick(); idle();
        cap_dr();
        bus.sh_DR = 1; tick(); idle();
        check("ovl.tdo_pre", 32'(bus.tdo), 32'h1);
        bus.c_DR = 1; bus.sh_DR = 1; tick(); idle();
        check("ovl.tdo_held", 32'(bus.tdo), 32'h1);
        shift_dr(32, 32'h0, q);
        check("ovl.idcode", q, 32'h1000_0001);

        // randomized strobes against the model
        rnd_chk = 1;
        for (int b = 0; b < 40; b++) begin
            case ($urandom_range(0, 2))
                0: load_ir(4'h1);
                1: load_ir(4'h2);
                default: load_ir(4'($urandom_range(0, 15)));
            endcase
            for (int c = 0; c < 30; c++) begin
                idle();
                bus.tdi = 1'($urandom_range(0, 1));
                reset = $urandom_range(0, 199) == 0;
                case ($urandom_range(0, 10))
                    1: bus.c_IR = 1;
                    2: bus.sh_IR = 1;
                    3: bus.u_IR = 1;
                    4: bus.c_DR = 1;
                    5, 6, 7: bus.sh_DR = 1;
                    8: bus.u_DR = 1;
                    9: bus.trst_st = 1;
                    default: ;
                endcase
                tick();
            end
        end
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
